// File: rtl/dpram_arbiter.sv
// ---------------------------------------------------------------------------
// dpram_arbiter
//
// Purpose:
//   Shares a simple dual-port RAM (one write port, one read port) between two
//   requesters, A and B.  The write port and the read port each have their
//   own round-robin arbiter, so a write from one requester and a read from
//   the other are both granted in the same cycle.  Grants are combinational;
//   read responses come back one cycle later, tagged with the owner that was
//   granted the read.
//
// Configuration:
//   DPRAM_ARB_FWD_EN - when defined, a write and a read to the same address
//                      in the same cycle return the new write data to the
//                      reader instead of the RAM's pre-write data.
//
// Ports:
//   clk                      clock, all state updates on the rising edge
//   rst                      asynchronous reset, active low
//   req_a / req_b            request strobes
//   op_a / op_b              1 = write, 0 = read
//   addr_a / addr_b          request addresses
//   wdata_a / wdata_b        write data
//   gnt_a / gnt_b            combinational grants
//   rvalid_a / rvalid_b      registered read-response strobes
//   rdata_a / rdata_b        read data, qualified by rvalid, held otherwise
//   ram_we / ram_wr_addr / ram_wr_data   RAM write port
//   ram_re / ram_rd_addr                 RAM read port
//   ram_rd_data              RAM read data, valid one cycle after ram_re
// ---------------------------------------------------------------------------
module dpram_arbiter #(
    parameter int DATA_WIDTH   = 8,
    parameter int ADDRESS_SIZE = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    req_a,
    input  logic                    req_b,
    input  logic                    op_a,
    input  logic                    op_b,
    input  logic [ADDRESS_SIZE-1:0] addr_a,
    input  logic [ADDRESS_SIZE-1:0] addr_b,
    input  logic [DATA_WIDTH-1:0]   wdata_a,
    input  logic [DATA_WIDTH-1:0]   wdata_b,
    output logic                    gnt_a,
    output logic                    gnt_b,
    output logic                    rvalid_a,
    output logic                    rvalid_b,
    output logic [DATA_WIDTH-1:0]   rdata_a,
    output logic [DATA_WIDTH-1:0]   rdata_b,
    output logic                    ram_we,
    output logic [ADDRESS_SIZE-1:0] ram_wr_addr,
    output logic [DATA_WIDTH-1:0]   ram_wr_data,
    output logic                    ram_re,
    output logic [ADDRESS_SIZE-1:0] ram_rd_addr,
    input  logic [DATA_WIDTH-1:0]   ram_rd_data
);

    // Which requester was granted last on a port (round-robin pointer),
    // and which requester owns the read currently in flight.
    typedef enum logic {
        LAST_A = 1'b0,
        LAST_B = 1'b1
    } last_t;

    typedef enum logic {
        OWNER_A = 1'b0,
        OWNER_B = 1'b1
    } owner_t;

    last_t  wr_last;
    last_t  rd_last;
    owner_t rd_owner;
    logic   rd_pending;

    logic wr_req_a;
    logic wr_req_b;
    logic rd_req_a;
    logic rd_req_b;
    logic wr_gnt_a;
    logic wr_gnt_b;
    logic rd_gnt_a;
    logic rd_gnt_b;

    logic [DATA_WIDTH-1:0] rsp_data;
    logic [DATA_WIDTH-1:0] rdata_a_q;
    logic [DATA_WIDTH-1:0] rdata_b_q;

`ifdef DPRAM_ARB_FWD_EN
    logic                  fwd_hit;
    logic [DATA_WIDTH-1:0] fwd_data;
`endif

    // Sort requests onto the two ports.  Requests are masked by reset so
    // that nothing is granted and the RAM ports stay idle while rst is low.
    always_comb begin
        wr_req_a = rst & req_a & op_a;
        wr_req_b = rst & req_b & op_b;
        rd_req_a = rst & req_a & ~op_a;
        rd_req_b = rst & req_b & ~op_b;
    end

    // Round-robin arbitration, one arbiter per port.  On contention the
    // requester that did not win last time on that port gets the grant.
    // A requester's op selects exactly one port, so it can never collect
    // more than one grant per cycle.
    always_comb begin
        wr_gnt_a = wr_req_a & (~wr_req_b | (wr_last == LAST_B));
        wr_gnt_b = wr_req_b & (~wr_req_a | (wr_last == LAST_A));
        rd_gnt_a = rd_req_a & (~rd_req_b | (rd_last == LAST_B));
        rd_gnt_b = rd_req_b & (~rd_req_a | (rd_last == LAST_A));
    end

    // Grants and RAM port routing.  Idle ports drive zero addresses/data so
    // the RAM interface is quiet outside of granted accesses.
    always_comb begin
        gnt_a       = wr_gnt_a | rd_gnt_a;
        gnt_b       = wr_gnt_b | rd_gnt_b;
        ram_we      = wr_gnt_a | wr_gnt_b;
        ram_wr_addr = '0;
        ram_wr_data = '0;
        ram_re      = rd_gnt_a | rd_gnt_b;
        ram_rd_addr = '0;
        if (wr_gnt_a) begin
            ram_wr_addr = addr_a;
            ram_wr_data = wdata_a;
        end else if (wr_gnt_b) begin
            ram_wr_addr = addr_b;
            ram_wr_data = wdata_b;
        end
        if (rd_gnt_a) begin
            ram_rd_addr = addr_a;
        end else if (rd_gnt_b) begin
            ram_rd_addr = addr_b;
        end
    end

    // Round-robin pointers only move when their port actually grants.
    // Reset leaves both at "B last" so A wins the first contention.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_last <= LAST_B;
            rd_last <= LAST_B;
        end else begin
            if (wr_gnt_a) begin
                wr_last <= LAST_A;
            end else if (wr_gnt_b) begin
                wr_last <= LAST_B;
            end
            if (rd_gnt_a) begin
                rd_last <= LAST_A;
            end else if (rd_gnt_b) begin
                rd_last <= LAST_B;
            end
        end
    end

    // Read-in-flight tracking.  Reset clears the pending flag, which drops
    // any response that was outstanding when reset hit.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rd_pending <= 1'b0;
            rd_owner   <= OWNER_A;
        end else begin
            rd_pending <= ram_re;
            if (ram_re) begin
                rd_owner <= rd_gnt_b ? OWNER_B : OWNER_A;
            end
        end
    end

`ifdef DPRAM_ARB_FWD_EN
    // Same-cycle write and read to one address: remember the write data so
    // the reader sees the new value rather than the RAM's old contents.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            fwd_hit  <= 1'b0;
            fwd_data <= '0;
        end else begin
            fwd_hit <= ram_we & ram_re & (ram_wr_addr == ram_rd_addr);
            if (ram_we) begin
                fwd_data <= ram_wr_data;
            end
        end
    end

    always_comb begin
        rsp_data = fwd_hit ? fwd_data : ram_rd_data;
    end
`else
    always_comb begin
        rsp_data = ram_rd_data;
    end
`endif

    always_comb begin
        rvalid_a = rd_pending & (rd_owner == OWNER_A);
        rvalid_b = rd_pending & (rd_owner == OWNER_B);
    end

    // rdata passes the response through in the rvalid cycle and keeps the
    // last delivered value afterwards.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rdata_a_q <= '0;
            rdata_b_q <= '0;
        end else begin
            if (rvalid_a) begin
                rdata_a_q <= rsp_data;
            end
            if (rvalid_b) begin
                rdata_b_q <= rsp_data;
            end
        end
    end

    always_comb begin
        rdata_a = rvalid_a ? rsp_data : rdata_a_q;
        rdata_b = rvalid_b ? rsp_data : rdata_b_q;
    end

endmodule

// File: doc/dpram_arbiter.md
DPRAM_ARBITER -- requirements
Module: dpram_arbiter

Interface
REQ-001 Parameter DATA_WIDTH, default 8, SHALL set the data width of the requesters and the RAM.
REQ-002 Parameter ADDRESS_SIZE, default 4, SHALL set the address width of the requesters and the RAM.
REQ-003 clk  input  1  SHALL be the single clock; all state SHALL update on its rising edge.
REQ-004 rst  input  1  SHALL be the reset: asynchronous, active-low.
REQ-005 req_a, req_b  input  1  SHALL be the request strobes, one per requester.
REQ-006 op_a, op_b  input  1  SHALL select the operation: 1 = write, 0 = read.
REQ-007 addr_a, addr_b  input  ADDRESS_SIZE  SHALL be the request addresses.
REQ-008 wdata_a, wdata_b  input  DATA_WIDTH  SHALL be the write data.
REQ-009 gnt_a, gnt_b  output  1  SHALL be the grants, combinational and in the same cycle as the request.
REQ-010 rvalid_a, rvalid_b  output  1  SHALL each be a registered read-response strobe.
REQ-011 rdata_a, rdata_b  output  DATA_WIDTH  SHALL be the read data, qualified by the matching rvalid.
REQ-012 ram_we, ram_wr_addr, ram_wr_data  output  1/ADDRESS_SIZE/DATA_WIDTH  SHALL drive the RAM write port.
REQ-013 ram_re, ram_rd_addr  output  1/ADDRESS_SIZE  SHALL drive the RAM read port.
REQ-014 ram_rd_data  input  DATA_WIDTH  SHALL be the RAM read data; it is valid 1 cycle after ram_re.

Function
REQ-015 The write port and the read port SHALL be arbitrated independently; a write from one requester and a read from the other SHALL both be granted in the same cycle.
REQ-016 Each port SHALL use a round-robin arbiter.
- On contention, the grant SHALL go to the requester not granted last on that port.
- The last-winner pointer SHALL update only when that port issues a grant.
REQ-017 An uncontended request SHALL be granted in the cycle it is asserted.
REQ-018 A requester SHALL hold req, op, addr and wdata stable until it is granted; a request that is not granted SHALL have no side effect.
REQ-019 On a write grant, the arbiter SHALL drive ram_we=1 and route the winner's addr and wdata to the RAM write port in the same cycle.
- ram_we SHALL be 0 otherwise.
REQ-020 On a read grant, the arbiter SHALL drive ram_re=1 and route the winner's addr to ram_rd_addr.
- A registered owner tag SHALL record which requester was granted.
REQ-021 Read latency SHALL be exactly 1 cycle.
- rvalid_x SHALL pulse high for 1 cycle, 1 cycle after gnt_x for a read.
- rdata_x SHALL equal ram_rd_data in that cycle.
REQ-022 rdata_x SHALL hold its last value while rvalid_x is 0.
REQ-023 Back-to-back reads SHALL sustain 1 read per cycle across the two requesters.
REQ-024 A write and a read to the same address in the same cycle SHALL return the pre-write data, unless forwarding is enabled (REQ-030).
REQ-025 Each requester SHALL receive at most one grant per cycle.

Reset
REQ-026 While rst=0, the arbiter SHALL hold:
- gnt_a, gnt_b, rvalid_a, rvalid_b, ram_we and ram_re at 0;
- rdata_a, rdata_b, ram_wr_addr, ram_wr_data and ram_rd_addr at 0;
- both round-robin pointers at "B last", so that A wins the first contention.
REQ-027 If reset asserts while a read is in flight, the response SHALL be discarded: no rvalid SHALL be issued after reset releases.
REQ-028 The first grant SHALL be possible in the first rising clock edge cycle after rst deasserts.

Configuration
REQ-029 The macro DPRAM_ARB_FWD_EN SHALL control write-to-read forwarding.
REQ-030 With DPRAM_ARB_FWD_EN defined:
- A same-cycle write grant and read grant to equal addresses SHALL set a registered hit flag and capture the write data.
- The next-cycle rdata_x SHALL return the captured write data instead of ram_rd_data.
REQ-031 Without DPRAM_ARB_FWD_EN, the forwarding logic SHALL be absent and REQ-024 SHALL apply.

Verification
REQ-032 The bench SHALL cover these scenarios:
- Reset then A write: req_a=1, op_a=1, addr_a=3, wdata_a=8'h5A -> gnt_a=1, ram_we=1, ram_wr_addr=3, ram_wr_data=8'h5A in the same cycle.
- Write contention: A and B both write on 3 consecutive cycles -> grants A, B, A.
- Concurrent ops: A writes addr 2 while B reads addr 7 (RAM holds 8'h11) -> gnt_a=gnt_b=1; next cycle rvalid_b=1, rdata_b=8'h11, rvalid_a=0.
- Collision: A writes 8'hC3 to addr 4 while B reads addr 4 (RAM holds 8'h00) -> rdata_b=8'h00 without DPRAM_ARB_FWD_EN, 8'hC3 with it.
- Reset mid-read: B read granted, rst=0 before the next edge -> rvalid_b stays 0 and all outputs stay 0.
- Back-to-back reads: A and B read continuously for 4 cycles -> 1 rvalid per cycle, alternating A and B.
